// File: rtl/alu_exec_stage.sv
// Execute stage: 2-entry command FIFO feeding an alu_9 instance, with a registered
// result/tag output and a consume counter. Define ALU_OPCHK_EN to flag opcodes above OP_MAX.

package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_SLT = 4'd8
    } alu_op_e;

endpackage

module alu_9
    import alu_exec_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_c
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // NOTE: o_c is assigned before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        o_c = '0;
        case (i_op)
            OP_ADD:  o_c = i_a + i_b;
            OP_SUB:  o_c = i_a - i_b;
            OP_AND:  o_c = i_a & i_b;
            OP_OR:   o_c = i_a | i_b;
            OP_XOR:  o_c = i_a ^ i_b;
            OP_SLL:  o_c = i_a << w_shamt;
            OP_SRL:  o_c = i_a >> w_shamt;
            OP_SRA:  o_c = $unsigned($signed(i_a) >>> w_shamt);
            OP_SLT:  o_c = {31'd0, $signed(i_a) < $signed(i_b)};
            default: o_c = '0;
        endcase
    end

endmodule

module alu_exec_stage #(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned OP_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      done_cnt
);

    if (OP_MAX > 15) begin : g_bad_op_max
        $error("alu_exec_stage: OP_MAX must fit the 4-bit opcode field");
    end

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_c;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
    logic [15:0]      r_done_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_consume;
    logic [1:0]       w_count_nxt;
    cmd_t             w_head;
    logic [31:0]      w_alu_c;
    logic [31:0]      w_res_c;
    logic             w_res_err;

    // A full FIFO already holds in_ready low, so a push never coincides with count == 2.
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = (r_count != 2'd0) && (!r_out_valid || out_ready);
    assign w_consume = r_out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    alu_9 u_alu (
        .i_a  (w_head.a),
        .i_b  (w_head.b),
        .i_op (w_head.op),
        .o_c  (w_alu_c)
    );

`ifdef ALU_OPCHK_EN
    localparam logic [3:0] OP_MAX_L = 4'(OP_MAX);

    logic w_illegal;

    assign w_illegal = (w_head.op > OP_MAX_L);
    assign w_res_c   = w_illegal ? 32'd0 : w_alu_c;
    assign w_res_err = w_illegal;
`else
    assign w_res_c   = w_alu_c;
    assign w_res_err = 1'b0;
`endif

    // NOTE: FIFO storage is deliberately not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
        end
    end

    // NOTE: every state register updates with <= so all of them sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_c     <= 32'd0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
            r_done_cnt  <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);

            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_c     <= w_res_c;
                r_out_tag   <= w_head.tag;
                r_out_err   <= w_res_err;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end

            if (w_consume) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign done_cnt  = r_done_cnt;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= 2'd2);

    a_ready_tracks_count: assert property (@(posedge clk) disable iff (reset)
        r_in_ready == (r_count != 2'd2));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (reset)
        (r_out_valid && !out_ready) |=>
            (r_out_valid && $stable(r_out_c) && $stable(r_out_tag) && $stable(r_out_err)));

endmodule
